rob_flushable: RTL
==================

Name: rob_flushable

Overview:
- Parametrised successor to the 16-entry, 4-wide reorder buffer. Generalised in depth, dispatch width, CDB count, commit width and operand read ports.
- Adds behaviour the fixed ROB lacks: branch-mispredict flush, all-or-nothing dispatch backpressure, and CDB bypass on operand reads.
- Sits between InstructionBuffer (dispatch, operand lookup), functional units via the CDB, BranchUnit (flush) and RegisterFile (commit writes).

Parameters:
- DEPTH, 16, number of entries; must be a power of 2 and ≥ 4. IDX_W = $clog2(DEPTH).
- DISPATCH_W, 4, dispatch lanes per cycle.
- CDB_W, 4, completion buses.
- COMMIT_W, 4, maximum in-order retirements per cycle.
- RD_PORTS, 8, operand lookup ports.
- DATA_W, 16, result width.
- REG_W, 4, architectural register index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- disp_valid  in  DISPATCH_W  per-lane request; set bits must form a prefix starting at lane 0.
- disp_rt  in  DISPATCH_W*REG_W  destination register per lane.
- disp_ready  out  1  dispatch accepted this cycle.
- disp_idx  out  DISPATCH_W*IDX_W  allocated index per lane, equal to tail+lane.
- cdb_valid  in  CDB_W  completion strobe.
- cdb_idx  in  CDB_W*IDX_W  completing entry.
- cdb_data  in  CDB_W*DATA_W  result.
- rd_idx  in  RD_PORTS*IDX_W  operand owner lookup.
- rd_ready  out  RD_PORTS  value available.
- rd_data  out  RD_PORTS*DATA_W  value.
- flush_valid  in  1  mispredict; discard every entry younger than flush_idx.
- flush_idx  in  IDX_W  last surviving entry (the branch).
- commit_valid  out  COMMIT_W  per-slot retirement; set bits form a prefix.
- commit_rt  out  COMMIT_W*REG_W  register target.
- commit_data  out  COMMIT_W*DATA_W  write data.
- commit_idx  out  COMMIT_W*IDX_W  writer tag, used by RegisterFile to clear busy.
- head  out  IDX_W  oldest entry.
- count  out  IDX_W+1  occupancy.
- empty, full  out  1 each.

Behaviour:
- State:
  - Per entry: valid, done, rt, data.
  - Pointers head and tail (IDX_W bits each, wrapping modulo DEPTH); count register.
- Reset (async): head=tail=0, count=0, all valid/done=0. All outputs then read 0 except empty=1. Reset mid-operation discards all entries immediately.
- Dispatch:
  - n = popcount(disp_valid). free = DEPTH-count, taken from the registered count; same-cycle commits do not free space.
  - disp_ready = (free ≥ n) && !flush_valid. Combinational; 1 when n=0.
  - If disp_ready, all n entries are allocated on the edge: valid=1, done=0, rt latched. tail += n, wrapping.
  - If not ready, no lane is accepted (all-or-nothing).
- Completion:
  - On the edge, each cdb_valid with a valid target entry sets done=1 and writes data.
  - A CDB hit on an invalid or flushed entry is ignored.
  - Two CDBs hitting the same index is illegal; the higher lane wins.
- Read ports (combinational):
  - rd_ready = entry done, or a CDB lane matching rd_idx this cycle (bypass; CDB data is returned).
  - Reads of an invalid entry return ready=0, data=0.
- Commit:
  - Slot k is valid iff entries head..head+k are all valid&&done, using registered done only. An entry completing this cycle commits the next cycle at the earliest.
  - On the edge: committed entries are cleared and head advances by the number committed.
  - Latency: dispatch→earliest commit = 2 edges (CDB in the cycle after dispatch, commit the cycle after that).
- Flush:
  - On the edge, every entry strictly younger than flush_idx is invalidated, and tail = flush_idx+1.
  - count = ((flush_idx-head) mod DEPTH)+1 minus commits this cycle.
  - Commit proceeds in the same cycle; committing flush_idx itself is legal.
  - flush_idx must reference a valid entry, otherwise behaviour is undefined; an SVA checks this.
  - CDB writes to surviving entries in the flush cycle are kept.
- count update: count_next = count + accepted − committed (no flush).
- full=(count==DEPTH), empty=(count==0).
- Wrap-around: indices are compared by age relative to head, never numerically.

Decomposition:
- Package rob_pkg holds:
  - IDX_W/count-width helper functions.
  - The entry struct typedef (valid, done, rt, data).
  - An age_lt(a, b, head) function.
- Sub-module rob_commit_select: COMMIT_W-wide prefix-ready scan from head. Outputs the commit mask and the committed count.

Test Plan:
- After reset, dispatch 4 lanes with rt 1,2,3,4 → disp_idx 0..3, count 4. CDB completes idx 0,1 next cycle → next cycle commit_valid=0011, rt 1,2, head=2.
- Fill to count 14, request 3 lanes → disp_ready=0, nothing allocated, tail unchanged. Request 2 → accepted, full=1.
- Head=14, dispatch 4 → indices 14,15,0,1. Complete all → commits in order 14,15,0,1, head=2.
- Entries 5..12 valid, flush_idx=7 → tail=8, count=3, entries 8..12 invalid. CDB to idx 9 in the same cycle → ignored.
- rd_idx=6 with cdb_valid on idx 6 (data 0xBEEF) in the same cycle → rd_ready=1, rd_data=0xBEEF before the edge.
- Assert rst while count=9 with commits pending → outputs clear asynchronously, empty=1, no commit_valid after release.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared types and helpers for the flushable reorder buffer.
package rob_pkg;

  // Entry payload widths; the ROB stores rt/data at these widths.
  localparam int ROB_DATA_W    = 16;
  localparam int ROB_REG_W     = 4;
  // Widest index the age helper handles.
  localparam int ROB_MAX_IDX_W = 16;

  // Index width for a power-of-two depth.
  function automatic int idx_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Occupancy width: must represent DEPTH itself.
  function automatic int count_width(input int depth);
    return idx_width(depth) + 1;
  endfunction

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic [ROB_REG_W-1:0]  rt;
    logic [ROB_DATA_W-1:0] data;
  } rob_entry_t;

  // True when a is strictly older than b. Ages are distances from head,
  // taken modulo DEPTH through mask (DEPTH-1), so wrap-around is harmless.
  function automatic logic age_lt(input logic [ROB_MAX_IDX_W-1:0] a,
                                  input logic [ROB_MAX_IDX_W-1:0] b,
                                  input logic [ROB_MAX_IDX_W-1:0] head,
                                  input logic [ROB_MAX_IDX_W-1:0] mask);
    logic [ROB_MAX_IDX_W-1:0] age_a;
    logic [ROB_MAX_IDX_W-1:0] age_b;
    age_a = (a - head) & mask;
    age_b = (b - head) & mask;
    return age_a < age_b;
  endfunction

endpackage

// File: rtl/rob_flushable_if.sv
// Bus bundle between the ROB and its neighbours (dispatch, CDB, operand
// reads, flush, commit and status).
//
// Handshake: dispatch is the only flow-controlled channel. A request
// (disp_valid, a prefix of lanes) is accepted on a rising edge where
// disp_ready is high; disp_ready is combinational from disp_valid, so the
// requester must not make disp_valid depend on disp_ready. CDB, flush and
// commit are strobes with no back-pressure: a set valid bit is consumed on
// that edge.
interface rob_flushable_if #(
  parameter int DEPTH      = 16,
  parameter int DISPATCH_W = 4,
  parameter int CDB_W      = 4,
  parameter int COMMIT_W   = 4,
  parameter int RD_PORTS   = 8,
  parameter int DATA_W     = 16,
  parameter int REG_W      = 4
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DISPATCH_W-1:0]       disp_valid;
  logic [DISPATCH_W*REG_W-1:0] disp_rt;
  logic                        disp_ready;
  logic [DISPATCH_W*IDX_W-1:0] disp_idx;

  logic [CDB_W-1:0]            cdb_valid;
  logic [CDB_W*IDX_W-1:0]      cdb_idx;
  logic [CDB_W*DATA_W-1:0]     cdb_data;

  logic [RD_PORTS*IDX_W-1:0]   rd_idx;
  logic [RD_PORTS-1:0]         rd_ready;
  logic [RD_PORTS*DATA_W-1:0]  rd_data;

  logic                        flush_valid;
  logic [IDX_W-1:0]            flush_idx;

  logic [COMMIT_W-1:0]         commit_valid;
  logic [COMMIT_W*REG_W-1:0]   commit_rt;
  logic [COMMIT_W*DATA_W-1:0]  commit_data;
  logic [COMMIT_W*IDX_W-1:0]   commit_idx;

  logic [IDX_W-1:0]            head;
  logic [IDX_W:0]              count;
  logic                        empty;
  logic                        full;

  // ROB side
  modport slave (
    input  disp_valid, disp_rt, cdb_valid, cdb_idx, cdb_data, rd_idx,
           flush_valid, flush_idx,
    output disp_ready, disp_idx, rd_ready, rd_data, commit_valid, commit_rt,
           commit_data, commit_idx, head, count, empty, full
  );

  // Pipeline side
  modport master (
    output disp_valid, disp_rt, cdb_valid, cdb_idx, cdb_data, rd_idx,
           flush_valid, flush_idx,
    input  disp_ready, disp_idx, rd_ready, rd_data, commit_valid, commit_rt,
           commit_data, commit_idx, head, count, empty, full
  );
endinterface

// File: rtl/rob_commit_select.sv
// In-order retirement scan: slot k retires only if slots 0..k are all ready.
module rob_commit_select #(
  parameter int COMMIT_W = 4,
  parameter int CNT_W    = 3
) (
  input  logic [COMMIT_W-1:0] slot_rdy,
  output logic [COMMIT_W-1:0] commit_mask,
  output logic [CNT_W-1:0]    commit_cnt
);

  logic run;

  // Prefix-AND of readiness starting at the head slot, plus its popcount
  always_comb begin
    run         = 1'b1;
    commit_mask = '0;
    commit_cnt  = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      run            = run & slot_rdy[k];
      commit_mask[k] = run;
      if (run) commit_cnt = commit_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rob_flushable.sv
// Parametrised reorder buffer with all-or-nothing dispatch, CDB bypass on
// operand reads, in-order multi-commit and branch-mispredict flush.
// Module parameters must match those of the connected interface instance.
// Entry rt/data are held at the package widths (ROB_REG_W/ROB_DATA_W).
module rob_flushable
  import rob_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DISPATCH_W = 4,
  parameter int CDB_W      = 4,
  parameter int COMMIT_W   = 4,
  parameter int RD_PORTS   = 8,
  parameter int DATA_W     = ROB_DATA_W,
  parameter int REG_W      = ROB_REG_W
) (
  input  logic           clk,
  input  logic           rst,
  rob_flushable_if.slave bus
);

  localparam int IDX_W  = idx_width(DEPTH);
  localparam int CNT_W  = count_width(DEPTH);
  localparam int CSEL_W = $clog2(COMMIT_W + 1);
  localparam int N_W    = $clog2(DISPATCH_W + 1);
  localparam logic [ROB_MAX_IDX_W-1:0] AGE_MASK = ROB_MAX_IDX_W'(DEPTH - 1);

  rob_entry_t       ent_q [DEPTH];
  rob_entry_t       ent_d [DEPTH];
  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [N_W-1:0]      disp_n;
  logic [CNT_W-1:0]    free_slots;
  logic                disp_ok;
  logic [IDX_W-1:0]    lane_idx [DISPATCH_W];
  logic [IDX_W-1:0]    slot_idx [COMMIT_W];
  logic [COMMIT_W-1:0] slot_rdy;
  logic [COMMIT_W-1:0] commit_mask;
  logic [CSEL_W-1:0]   commit_cnt;
  logic [IDX_W-1:0]    flush_age;
  logic [IDX_W-1:0]    ridx;
  logic                byp;
  logic [DATA_W-1:0]   bdata;
  logic [IDX_W-1:0]    cidx;

  // Dispatch sizing: lane count, free space from the registered count only,
  // single grant for the whole group (blocked during a flush)
  always_comb begin
    disp_n = '0;
    for (int l = 0; l < DISPATCH_W; l++) begin
      lane_idx[l] = tail_q + IDX_W'(l);
      if (bus.disp_valid[l]) disp_n = disp_n + N_W'(1);
    end
    free_slots = CNT_W'(DEPTH) - count_q;
    disp_ok    = !rst && !bus.flush_valid && (free_slots >= CNT_W'(disp_n));
  end

  assign bus.disp_ready = disp_ok;

  // Allocated index per requesting lane; idle lanes read 0
  always_comb begin
    bus.disp_idx = '0;
    for (int l = 0; l < DISPATCH_W; l++) begin
      if (bus.disp_valid[l]) bus.disp_idx[l*IDX_W +: IDX_W] = lane_idx[l];
    end
  end

  // Commit candidates: registered valid&&done of the slots from head onward
  always_comb begin
    for (int k = 0; k < COMMIT_W; k++) begin
      slot_idx[k] = head_q + IDX_W'(k);
      slot_rdy[k] = ent_q[slot_idx[k]].valid && ent_q[slot_idx[k]].done;
    end
  end

  rob_commit_select #(
    .COMMIT_W (COMMIT_W),
    .CNT_W    (CSEL_W)
  ) u_commit_select (
    .slot_rdy    (slot_rdy),
    .commit_mask (commit_mask),
    .commit_cnt  (commit_cnt)
  );

  // Retirement outputs; unused slots read 0
  always_comb begin
    bus.commit_valid = commit_mask;
    bus.commit_rt    = '0;
    bus.commit_data  = '0;
    bus.commit_idx   = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      if (commit_mask[k]) begin
        bus.commit_rt[k*REG_W +: REG_W]    = REG_W'(ent_q[slot_idx[k]].rt);
        bus.commit_data[k*DATA_W +: DATA_W] = DATA_W'(ent_q[slot_idx[k]].data);
        bus.commit_idx[k*IDX_W +: IDX_W]   = slot_idx[k];
      end
    end
  end

  // Operand lookup: stored result, or this cycle's CDB value (highest lane)
  always_comb begin
    bus.rd_ready = '0;
    bus.rd_data  = '0;
    ridx         = '0;
    byp          = 1'b0;
    bdata        = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      ridx  = bus.rd_idx[p*IDX_W +: IDX_W];
      byp   = 1'b0;
      bdata = '0;
      for (int c = 0; c < CDB_W; c++) begin
        if (bus.cdb_valid[c] && (bus.cdb_idx[c*IDX_W +: IDX_W] == ridx)) begin
          byp   = 1'b1;
          bdata = bus.cdb_data[c*DATA_W +: DATA_W];
        end
      end
      if (ent_q[ridx].valid) begin
        bus.rd_ready[p] = ent_q[ridx].done || byp;
        if (byp) begin
          bus.rd_data[p*DATA_W +: DATA_W] = bdata;
        end else if (ent_q[ridx].done) begin
          bus.rd_data[p*DATA_W +: DATA_W] = DATA_W'(ent_q[ridx].data);
        end
      end
    end
  end

  // Entry next state: completion, then flush, then retirement, then allocation
  always_comb begin
    cidx = '0;
    for (int i = 0; i < DEPTH; i++) ent_d[i] = ent_q[i];
    for (int c = 0; c < CDB_W; c++) begin
      cidx = bus.cdb_idx[c*IDX_W +: IDX_W];
      if (bus.cdb_valid[c] && ent_q[cidx].valid) begin
        ent_d[cidx].done = 1'b1;
        ent_d[cidx].data = ROB_DATA_W'(bus.cdb_data[c*DATA_W +: DATA_W]);
      end
    end
    if (bus.flush_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (age_lt(ROB_MAX_IDX_W'(bus.flush_idx), ROB_MAX_IDX_W'(i),
                   ROB_MAX_IDX_W'(head_q), AGE_MASK)) begin
          ent_d[i] = '0;
        end
      end
    end
    for (int k = 0; k < COMMIT_W; k++) begin
      if (commit_mask[k]) ent_d[slot_idx[k]] = '0;
    end
    if (disp_ok) begin
      for (int l = 0; l < DISPATCH_W; l++) begin
        if (bus.disp_valid[l]) begin
          ent_d[lane_idx[l]].valid = 1'b1;
          ent_d[lane_idx[l]].done  = 1'b0;
          ent_d[lane_idx[l]].rt    = ROB_REG_W'(bus.disp_rt[l*REG_W +: REG_W]);
          ent_d[lane_idx[l]].data  = '0;
        end
      end
    end
  end

  // Pointer and occupancy next state; flush rebuilds count from head..flush_idx
  always_comb begin
    flush_age = bus.flush_idx - head_q;
    head_d    = head_q + IDX_W'(commit_cnt);
    if (bus.flush_valid) begin
      tail_d  = bus.flush_idx + IDX_W'(1);
      count_d = CNT_W'(flush_age) + CNT_W'(1) - CNT_W'(commit_cnt);
    end else if (disp_ok) begin
      tail_d  = tail_q + IDX_W'(disp_n);
      count_d = count_q + CNT_W'(disp_n) - CNT_W'(commit_cnt);
    end else begin
      tail_d  = tail_q;
      count_d = count_q - CNT_W'(commit_cnt);
    end
  end

  // State registers; reset empties the buffer immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign bus.head  = head_q;
  assign bus.count = count_q;
  assign bus.empty = (count_q == '0);
  assign bus.full  = (count_q == CNT_W'(DEPTH));

  // A flush must name a live entry, otherwise the surviving window is meaningless
  a_flush_idx_live: assert property (@(posedge clk) disable iff (rst)
    bus.flush_valid |-> ent_q[bus.flush_idx].valid);

endmodule
